arb_2m1s: RTL and testbench

Two-master, one-slave arbiter on the MemSplit32 split-transaction bus. It is the converging counterpart of the address-split fan-out: instruction and data ports, or two tiles, share one memory or IO slave. It arbitrates requests round-robin and locks a grant until it is acknowledged. It tracks outstanding reads in an in-order ID FIFO so each slave response returns to the master that issued the read.

---
 rtl/arb_2m1s.sv | 169 ++++++++++++++++
 tb/tb_arb_2m1s.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arb_2m1s.sv
// Two-master, one-slave MemSplit32 arbiter: round-robin grant with lock-until-ack,
// plus an in-order read ID FIFO that steers each slave response back to its issuer.
module arb_2m1s #(
    parameter int RD_DEPTH = 4,
    parameter bit M0_FIRST = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [3:0]  m0_be,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic        m0_resp,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [3:0]  m1_be,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic        m1_resp,
    output logic [31:0] m1_rdata,
    output logic        s_req,
    output logic        s_we,
    output logic [31:0] s_addr,
    output logic [3:0]  s_be,
    output logic [31:0] s_wdata,
    input  logic        s_ack,
    input  logic        s_resp,
    input  logic [31:0] s_rdata
);

    // state      | meaning
    // ST_IDLE    | no grant pending, arbitrate freely
    // ST_HOLD_M0 | m0 presented to slave but not yet acked
    // ST_HOLD_M1 | m1 presented to slave but not yet acked
    typedef enum logic [1:0] {ST_IDLE, ST_HOLD_M0, ST_HOLD_M1} state_t;

    localparam int          PW   = (RD_DEPTH > 1) ? $clog2(RD_DEPTH) : 1;
    localparam logic [PW:0] FULL = (PW + 1)'(RD_DEPTH);

    state_t          state;
    state_t          state_nxt;
    logic            prio;
    logic            sel_vld;
    logic            sel_id;
    logic            sel_we;
    logic            stall;
    logic            xfer;
    logic            push;
    logic            pop;
    logic            head_id;
    logic            head_vld;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW:0]     count;
    logic            id_mem [RD_DEPTH];

    always_comb begin
        sel_vld = 1'b0;
        sel_id  = 1'b0;
        case (state)
            ST_HOLD_M0: begin
                sel_vld = 1'b1;
                sel_id  = 1'b0;
            end
            ST_HOLD_M1: begin
                sel_vld = 1'b1;
                sel_id  = 1'b1;
            end
            default: begin
                if (m0_req && m1_req) begin
                    sel_vld = 1'b1;
                    sel_id  = prio;
                end else if (m0_req) begin
                    sel_vld = 1'b1;
                    sel_id  = 1'b0;
                end else if (m1_req) begin
                    sel_vld = 1'b1;
                    sel_id  = 1'b1;
                end
            end
        endcase
    end

    // Stall looks at the registered count only, so a pop in this cycle frees a slot next cycle.
    assign sel_we   = sel_id ? m1_we : m0_we;
    assign stall    = sel_vld && !sel_we && (count == FULL);
    assign xfer     = s_req && s_ack;
    assign push     = xfer && !sel_we;
    assign head_vld = (count != '0);
    assign head_id  = id_mem[rd_ptr];
    assign pop      = s_resp && head_vld;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state  <= ST_IDLE;
            prio   <= ~M0_FIRST;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            state <= state_nxt;
            if (xfer) prio <= ~sel_id;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) id_mem[wr_ptr] <= sel_id;
    end

    always_comb begin
        state_nxt = state;
        if (s_req) begin
            if (s_ack)       state_nxt = ST_IDLE;
            else if (sel_id) state_nxt = ST_HOLD_M1;
            else             state_nxt = ST_HOLD_M0;
        end
    end

    always_comb begin
        s_req    = 1'b0;
        s_we     = 1'b0;
        s_addr   = '0;
        s_be     = '0;
        s_wdata  = '0;
        m0_ack   = 1'b0;
        m1_ack   = 1'b0;
        m0_resp  = 1'b0;
        m1_resp  = 1'b0;
        m0_rdata = '0;
        m1_rdata = '0;
        if (rst_ni && sel_vld && !stall) begin
            s_req   = 1'b1;
            s_we    = sel_we;
            s_addr  = sel_id ? m1_addr  : m0_addr;
            s_be    = sel_id ? m1_be    : m0_be;
            s_wdata = sel_id ? m1_wdata : m0_wdata;
            m0_ack  = !sel_id && s_ack;
            m1_ack  = sel_id && s_ack;
        end
        if (rst_ni && pop) begin
            if (head_id) begin
                m1_resp  = 1'b1;
                m1_rdata = s_rdata;
            end else begin
                m0_resp  = 1'b1;
                m0_rdata = s_rdata;
            end
        end
    end

    // A response with nothing outstanding has no owner and is dropped.
    always_ff @(posedge clk_i) begin
        if (rst_ni && s_resp) begin
            assert (head_vld) else $warning("arb_2m1s: spurious slave response dropped");
        end
    end

endmodule

// File: tb/tb_arb_2m1s.sv
// Directed bench for arb_2m1s: reset, single read, round-robin, lock, interleaved reads,
// read stall on a full ID FIFO, and reset with reads outstanding.
module tb_arb_2m1s;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_be, m1_be;
    logic        m0_ack, m0_resp, m1_ack, m1_resp;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_req, s_we, s_ack, s_resp;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_be;

    int nvec = 0;
    int nerr = 0;

    always #5 clk_i = ~clk_i;

    arb_2m1s #(.RD_DEPTH(4), .M0_FIRST(1'b1)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_be(m0_be), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_resp(m0_resp), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_be(m1_be), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_resp(m1_resp), .m1_rdata(m1_rdata),
        .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_be(s_be), .s_wdata(s_wdata),
        .s_ack(s_ack), .s_resp(s_resp), .s_rdata(s_rdata)
    );

    task automatic clr_inputs();
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_be = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_be = 0; m1_wdata = 0;
        s_ack = 0; s_resp = 0; s_rdata = 0;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        clr_inputs();
        rst_ni = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk_i);
        rst_ni = 1'b0;
        m0_req = 1; m0_we = 1; m0_addr = 32'h1234; m0_be = 4'hF; m0_wdata = 32'h5555;
        s_ack = 1; s_resp = 1; s_rdata = 32'hFFFF_FFFF;
        #1;
        nvec++;
        if ({s_req, s_we, s_addr, s_be, s_wdata} !== 70'h0) begin
            nerr++; $display("FAIL reset_s_outputs: got req=%b addr=%h exp all zero", s_req, s_addr);
        end
        nvec++;
        if ({m0_ack, m0_resp, m0_rdata, m1_ack, m1_resp, m1_rdata} !== 68'h0) begin
            nerr++; $display("FAIL reset_m_outputs: got m0_ack=%b m0_resp=%b exp all zero", m0_ack, m0_resp);
        end
        @(negedge clk_i);
        clr_inputs();
        rst_ni = 1'b1;
        #1;
        nvec++;
        if (dut.count !== 3'd0) begin
            nerr++; $display("FAIL reset_count: got %0d exp 0", dut.count);
        end
    endtask

    task automatic test_single_read();
        @(negedge clk_i);
        m0_req = 1; m0_we = 0; m0_addr = 32'h100; m0_be = 4'hF; s_ack = 1;
        #1;
        nvec++;
        if (s_req !== 1'b1 || s_addr !== 32'h100 || s_we !== 1'b0) begin
            nerr++; $display("FAIL single_fwd: got req=%b addr=%h we=%b exp 1 00000100 0", s_req, s_addr, s_we);
        end
        nvec++;
        if (m0_ack !== 1'b1 || m1_ack !== 1'b0) begin
            nerr++; $display("FAIL single_ack: got m0=%b m1=%b exp 1 0", m0_ack, m1_ack);
        end
        @(negedge clk_i);
        clr_inputs();
        #1;
        nvec++;
        if (dut.count !== 3'd1) begin
            nerr++; $display("FAIL single_count_push: got %0d exp 1", dut.count);
        end
        @(negedge clk_i);
        s_resp = 1; s_rdata = 32'hDEADBEEF;
        #1;
        nvec++;
        if (m0_resp !== 1'b1 || m0_rdata !== 32'hDEADBEEF) begin
            nerr++; $display("FAIL single_m0_resp: got %b %h exp 1 deadbeef", m0_resp, m0_rdata);
        end
        nvec++;
        if (m1_resp !== 1'b0 || m1_rdata !== 32'h0) begin
            nerr++; $display("FAIL single_m1_quiet: got %b %h exp 0 00000000", m1_resp, m1_rdata);
        end
        @(negedge clk_i);
        clr_inputs();
        #1;
        nvec++;
        if (dut.count !== 3'd0) begin
            nerr++; $display("FAIL single_count_pop: got %0d exp 0", dut.count);
        end
    endtask

    task automatic test_round_robin();
        logic exp_m0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            m0_req = 1; m0_we = 1; m0_addr = 32'hA0; m0_be = 4'hF; m0_wdata = 32'h1;
            m1_req = 1; m1_we = 1; m1_addr = 32'hB0; m1_be = 4'h3; m1_wdata = 32'h2;
            s_ack = 1;
            #1;
            exp_m0 = (i % 2 == 0);
            nvec++;
            if (m0_ack !== exp_m0 || m1_ack !== !exp_m0) begin
                nerr++; $display("FAIL rr_ack[%0d]: got m0=%b m1=%b exp %b %b", i, m0_ack, m1_ack, exp_m0, !exp_m0);
            end
            nvec++;
            if (s_addr !== (exp_m0 ? 32'hA0 : 32'hB0)) begin
                nerr++; $display("FAIL rr_addr[%0d]: got %h exp %h", i, s_addr, exp_m0 ? 32'hA0 : 32'hB0);
            end
        end
        @(negedge clk_i);
        clr_inputs();
    endtask

    task automatic test_lock();
        do_reset();
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk_i);
            m1_req = (c <= 4); m1_we = 1; m1_addr = 32'h2000; m1_be = 4'hF; m1_wdata = 32'hCAFE;
            m0_req = (c >= 2); m0_we = 1; m0_addr = 32'h1000; m0_be = 4'hF; m0_wdata = 32'hBEEF;
            s_ack  = (c >= 4);
            #1;
            if (c <= 4) begin
                nvec++;
                if (s_addr !== 32'h2000 || s_wdata !== 32'hCAFE || s_req !== 1'b1) begin
                    nerr++; $display("FAIL lock_hold[%0d]: got addr=%h wdata=%h exp 00002000 0000cafe", c, s_addr, s_wdata);
                end
                nvec++;
                if (m0_ack !== 1'b0 || m1_ack !== (c == 4)) begin
                    nerr++; $display("FAIL lock_ack[%0d]: got m0=%b m1=%b exp 0 %b", c, m0_ack, m1_ack, c == 4);
                end
            end else begin
                nvec++;
                if (m0_ack !== 1'b1 || s_addr !== 32'h1000) begin
                    nerr++; $display("FAIL lock_next: got m0_ack=%b addr=%h exp 1 00001000", m0_ack, s_addr);
                end
            end
        end
        @(negedge clk_i);
        clr_inputs();
    endtask

    task automatic test_interleaved();
        do_reset();
        @(negedge clk_i);
        m0_req = 1; m0_we = 0; m0_addr = 32'h10; s_ack = 1;
        #1;
        nvec++;
        if (m0_ack !== 1'b1) begin
            nerr++; $display("FAIL il_ack0: got %b exp 1", m0_ack);
        end
        @(negedge clk_i);
        m0_req = 0; m1_req = 1; m1_we = 0; m1_addr = 32'h20;
        #1;
        nvec++;
        if (m1_ack !== 1'b1 || s_addr !== 32'h20) begin
            nerr++; $display("FAIL il_ack1: got %b %h exp 1 00000020", m1_ack, s_addr);
        end
        @(negedge clk_i);
        m1_req = 0; m0_req = 1; m0_addr = 32'h30;
        s_resp = 1; s_rdata = 32'hA;
        #1;
        nvec++;
        if (m0_ack !== 1'b1 || m0_resp !== 1'b1 || m0_rdata !== 32'hA || m1_resp !== 1'b0) begin
            nerr++; $display("FAIL il_resp_a: got ack=%b resp=%b rdata=%h exp 1 1 0000000a", m0_ack, m0_resp, m0_rdata);
        end
        @(negedge clk_i);
        m0_req = 0; s_ack = 0; s_rdata = 32'hB;
        #1;
        nvec++;
        if (dut.count !== 3'd2) begin
            nerr++; $display("FAIL il_count_pushpop: got %0d exp 2", dut.count);
        end
        nvec++;
        if (m1_resp !== 1'b1 || m1_rdata !== 32'hB || m0_resp !== 1'b0 || m0_rdata !== 32'h0) begin
            nerr++; $display("FAIL il_resp_b: got m1=%b %h m0=%b exp 1 0000000b 0", m1_resp, m1_rdata, m0_resp);
        end
        @(negedge clk_i);
        s_rdata = 32'hC;
        #1;
        nvec++;
        if (m0_resp !== 1'b1 || m0_rdata !== 32'hC || m1_resp !== 1'b0) begin
            nerr++; $display("FAIL il_resp_c: got m0=%b %h m1=%b exp 1 0000000c 0", m0_resp, m0_rdata, m1_resp);
        end
        @(negedge clk_i);
        clr_inputs();
        #1;
        nvec++;
        if (dut.count !== 3'd0) begin
            nerr++; $display("FAIL il_count_end: got %0d exp 0", dut.count);
        end
    endtask

    task automatic test_read_stall();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            m0_req = 1; m0_we = 0; m0_addr = 32'h40 + i; s_ack = 1;
        end
        @(negedge clk_i);
        m0_addr = 32'h50;
        #1;
        nvec++;
        if (dut.count !== 3'd4 || s_req !== 1'b0 || m0_ack !== 1'b0) begin
            nerr++; $display("FAIL stall_full: got count=%0d s_req=%b ack=%b exp 4 0 0", dut.count, s_req, m0_ack);
        end
        @(negedge clk_i);
        m1_req = 1; m1_we = 1; m1_addr = 32'h60; m1_wdata = 32'h77;
        #1;
        nvec++;
        if (s_req !== 1'b1 || m1_ack !== 1'b1 || m0_ack !== 1'b0 || s_addr !== 32'h60) begin
            nerr++; $display("FAIL stall_write_pass: got s_req=%b m1_ack=%b m0_ack=%b addr=%h exp 1 1 0 00000060", s_req, m1_ack, m0_ack, s_addr);
        end
        @(negedge clk_i);
        m1_req = 0; m1_we = 0; s_resp = 1; s_rdata = 32'h99;
        #1;
        nvec++;
        if (s_req !== 1'b0 || m0_ack !== 1'b0 || m0_resp !== 1'b1) begin
            nerr++; $display("FAIL stall_pop_cycle: got s_req=%b ack=%b resp=%b exp 0 0 1", s_req, m0_ack, m0_resp);
        end
        @(negedge clk_i);
        s_resp = 0;
        #1;
        nvec++;
        if (s_req !== 1'b1 || m0_ack !== 1'b1 || s_addr !== 32'h50) begin
            nerr++; $display("FAIL stall_release: got s_req=%b ack=%b addr=%h exp 1 1 00000050", s_req, m0_ack, s_addr);
        end
        @(negedge clk_i);
        clr_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        @(negedge clk_i);
        m0_req = 1; m0_we = 0; m0_addr = 32'h300; s_ack = 1;
        @(negedge clk_i);
        m0_req = 0; m1_req = 1; m1_we = 0; m1_addr = 32'h400;
        @(negedge clk_i);
        rst_ni = 1'b0;
        m1_req = 0; m0_req = 1; s_resp = 1; s_rdata = 32'h55;
        #1;
        nvec++;
        if ({s_req, s_addr, m0_ack, m1_ack, m0_resp, m1_resp, m0_rdata, m1_rdata} !== 101'h0) begin
            nerr++; $display("FAIL midrst_zero: got s_req=%b m0_resp=%b m0_rdata=%h exp all zero", s_req, m0_resp, m0_rdata);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        m0_req = 0; s_ack = 0; s_resp = 1; s_rdata = 32'h77;
        #1;
        nvec++;
        if (m0_resp !== 1'b0 || m1_resp !== 1'b0 || m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin
            nerr++; $display("FAIL midrst_spurious: got m0=%b %h m1=%b %h exp 0 0", m0_resp, m0_rdata, m1_resp, m1_rdata);
        end
        nvec++;
        if (dut.count !== 3'd0) begin
            nerr++; $display("FAIL midrst_count: got %0d exp 0", dut.count);
        end
        @(negedge clk_i);
        clr_inputs();
        #1;
        nvec++;
        if (dut.count !== 3'd0) begin
            nerr++; $display("FAIL midrst_count_after: got %0d exp 0", dut.count);
        end
    endtask

    initial begin
        rst_ni = 1'b0;
        clr_inputs();
        repeat (2) @(negedge clk_i);
        test_reset();
        test_single_read();
        test_round_robin();
        test_lock();
        test_interleaved();
        test_read_stall();
        test_reset_mid();
        repeat (2) @(negedge clk_i);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
